// File: rtl/if_pc_pkg.sv
// if_pc_pkg: shared state encoding, default addresses and alignment helper for the IF PC controller.
package if_pc_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALTED = 2'd3} state_t;
    localparam int          DEF_INST_BYTES = 4;
    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
    function automatic logic [31:0] align_mask(input int inst_bytes);
        return 32'(inst_bytes - 1);
    endfunction
endpackage

// File: rtl/if_pc_next_sel.sv
// if_pc_next_sel: combinational next-PC priority select with redirect alignment check.
module if_pc_next_sel import if_pc_pkg::*; #(
    parameter int                 NB_ADDR    = 32,
    parameter int                 INST_BYTES = DEF_INST_BYTES,
    parameter logic [NB_ADDR-1:0] EXC_VECTOR = NB_ADDR'(DEF_EXC_VECTOR)
) (
    input  logic [NB_ADDR-1:0] pc_plus,
    input  logic               stall,
    input  logic               exc,
    input  logic               branch_taken,
    input  logic [NB_ADDR-1:0] branch_target,
    input  logic               jump,
    input  logic [NB_ADDR-1:0] jump_target,
    output logic [NB_ADDR-1:0] next_pc,
    output logic               upd,
    output logic               misalign
);
    localparam logic [NB_ADDR-1:0] MASK = NB_ADDR'(align_mask(INST_BYTES));
    logic br_bad, jp_bad;
    always_comb begin
        br_bad   = |(branch_target & MASK);
        jp_bad   = |(jump_target & MASK);
        next_pc  = exc ? EXC_VECTOR :
                   branch_taken ? (br_bad ? EXC_VECTOR : branch_target) :
                   jump ? (jp_bad ? EXC_VECTOR : jump_target) : pc_plus;
        upd      = exc || branch_taken || !stall;
        misalign = !exc && (branch_taken ? br_bad : (jump && !stall && jp_bad));
    end
endmodule

// File: rtl/if_pc_ctrl.sv
// if_pc_ctrl: IF-stage PC register with run/step/halt FSM and retired-fetch counter.
module if_pc_ctrl import if_pc_pkg::*; #(
    parameter int                 NB_ADDR    = 32,
    parameter int                 NB_CNT     = 32,
    parameter int                 INST_BYTES = DEF_INST_BYTES,
    parameter logic [NB_ADDR-1:0] RESET_ADDR = NB_ADDR'(DEF_RESET_ADDR),
    parameter logic [NB_ADDR-1:0] EXC_VECTOR = NB_ADDR'(DEF_EXC_VECTOR)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_exc,
    input  logic               i_branch_taken,
    input  logic [NB_ADDR-1:0] i_branch_target,
    input  logic               i_jump,
    input  logic [NB_ADDR-1:0] i_jump_target,
    input  logic               i_halt,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_ADDR-1:0] o_pc_plus,
    output logic               o_valid,
    output logic               o_halted,
    output logic               o_misalign,
    output logic [NB_CNT-1:0]  o_fetch_cnt
);
    state_t             state, state_nxt;
    logic [NB_ADDR-1:0] pc_sel;
    logic               upd, mis, permit, halt_go, apply, start_go;

    assign o_pc_plus = o_pc + NB_ADDR'(INST_BYTES);

    if_pc_next_sel #(
        .NB_ADDR    (NB_ADDR),
        .INST_BYTES (INST_BYTES),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc_plus       (o_pc_plus),
        .stall         (i_stall),
        .exc           (i_exc),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .next_pc       (pc_sel),
        .upd           (upd),
        .misalign      (mis)
    );

    // Any redirect in the same cycle squashes the halt.
    always_comb begin
        permit    = (state == S_RUN) || (state == S_STEP && i_step);
        halt_go   = permit && i_halt && !i_stall && !i_exc && !i_branch_taken && !i_jump;
        apply     = permit && upd && !halt_go;
        start_go  = i_start && (state == S_IDLE || state == S_HALTED);
        state_nxt = start_go ? (i_step_mode ? S_STEP : S_RUN) : halt_go ? S_HALTED : state;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            o_pc        <= RESET_ADDR;
            o_valid     <= 1'b0;
            o_halted    <= 1'b0;
            o_misalign  <= 1'b0;
            o_fetch_cnt <= '0;
        end else begin
            state       <= state_nxt;
            o_pc        <= start_go ? RESET_ADDR : apply ? pc_sel : o_pc;
            o_fetch_cnt <= o_fetch_cnt + NB_CNT'(apply);
            o_valid     <= (state_nxt == S_RUN) || (state_nxt == S_STEP && apply);
            o_halted    <= state_nxt == S_HALTED;
            o_misalign  <= apply && mis;
        end
    end
endmodule
